// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to count 0..v-1 (at least 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cell: d = x - y - bi, borrow out in bo.
module full_subtractor (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = X - Y - Bin, LSB first.
// start/ready accepts a request; valid/ack hands over the registered result.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             ovf,
    output logic             zero,
    output logic             valid,
    input  logic             ack
);

    localparam int CW = clog2(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] xs, ys, rs;
    logic [CW-1:0]    cnt;
    logic             b;
    logic             xm, ym;     // operand sign bits, kept since xs/ys shift away
    logic             dbit, bnext;
    logic             accept, last;
    logic [WIDTH-1:0] dfinal;

    full_subtractor u_cell (
        .d  (dbit),
        .bo (bnext),
        .x  (xs[0]),
        .y  (ys[0]),
        .bi (b)
    );

    assign ready  = (state == IDLE);
    assign valid  = (state == DONE);
    assign accept = ready && start;
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // The last bit goes straight to D rather than through the shift register.
    assign dfinal = {dbit, rs[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; start in RUN/DONE is ignored, ack only matters in DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    if (ack)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and per-bit shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs  <= '0;
            ys  <= '0;
            rs  <= '0;
            cnt <= '0;
            b   <= 1'b0;
            xm  <= 1'b0;
            ym  <= 1'b0;
        end else if (accept) begin
            xs  <= X;
            ys  <= Y;
            rs  <= '0;
            cnt <= '0;
            b   <= Bin;
            xm  <= X[WIDTH-1];
            ym  <= Y[WIDTH-1];
        end else if (state == RUN) begin
            xs  <= {1'b0, xs[WIDTH-1:1]};
            ys  <= {1'b0, ys[WIDTH-1:1]};
            rs  <= dfinal;
            cnt <= cnt + CW'(1);
            b   <= bnext;
        end
    end

    // Result registers, updated only on the final bit and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D    <= '0;
            Bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (last) begin
            D    <= dfinal;
            Bout <= bnext;
            ovf  <= (xm != ym) && (dbit != xm);
            zero <= (dfinal == '0);
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH 8 and 16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst, start, ack, bin, sel;
    logic [31:0] x, y;

    logic        rdy8, bo8, ov8, z8, v8;
    logic [7:0]  d8;
    logic        rdy16, bo16, ov16, z16, v16;
    logic [15:0] d16;

    logic        rdy, bo, ov, zr, vld;
    logic [31:0] dobs;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start & ~sel), .X(x[7:0]), .Y(y[7:0]), .Bin(bin),
        .ready(rdy8), .D(d8), .Bout(bo8), .ovf(ov8), .zero(z8), .valid(v8), .ack(ack & ~sel)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start & sel), .X(x[15:0]), .Y(y[15:0]), .Bin(bin),
        .ready(rdy16), .D(d16), .Bout(bo16), .ovf(ov16), .zero(z16), .valid(v16), .ack(ack & sel)
    );

    assign rdy  = sel ? rdy16 : rdy8;
    assign bo   = sel ? bo16  : bo8;
    assign ov   = sel ? ov16  : ov8;
    assign zr   = sel ? z16   : z8;
    assign vld  = sel ? v16   : v8;
    assign dobs = sel ? {16'h0, d16} : {24'h0, d8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, flags from first principles.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] bb, input logic bi,
                         output logic [31:0] ed, output logic eb, output logic eo, output logic ez);
        longint full, mask;
        mask = (64'sd1 <<< w) - 1;
        full = longint'(a) - longint'(bb) - longint'(bi);
        ed   = 32'(full & mask);
        eb   = (full < 0);
        eo   = (a[w-1] != bb[w-1]) && (ed[w-1] != a[w-1]);
        ez   = (ed == 0);
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] bb, input logic bi);
        @(negedge clk);
        x = a; y = bb; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat);
        int i;
        for (i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (vld) break;
        end
        chk("latency", i, exp_lat);
    endtask

    task automatic check_res(input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
        chk("D", dobs, ed);
        chk("Bout", bo, eb);
        chk("ovf", ov, eo);
        chk("zero", zr, ez);
    endtask

    task automatic finish_ack(input int dly);
        repeat (dly) begin
            @(negedge clk);
            chk("hold_valid", vld, 1);
        end
        chk("busy_ready", rdy, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_valid", vld, 0);
        chk("ack_ready", rdy, 1);
    endtask

    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] bb, input logic bi,
                          input logic [31:0] ed, input logic eb, input logic eo, input logic ez,
                          input int dly);
        sel = (w == 16);
        launch(a, bb, bi);
        wait_valid(w);
        check_res(ed, eb, eo, ez);
        finish_ack(dly);
    endtask

    initial begin
        logic [31:0] ed, ra, rb, msk;
        logic        eb, eo, ez, rbi;
        int          w;

        rst = 1'b1; start = 1'b0; ack = 1'b0; bin = 1'b0; sel = 1'b0; x = '0; y = '0;
        @(negedge clk);
        chk("rst_ready", rdy, 1);
        chk("rst_valid", vld, 0);
        chk("rst_D", dobs, 0);
        chk("rst_flags", {bo, ov, zr}, 0);
        rst = 1'b0;

        // Hand-computed WIDTH=8 vectors.
        run_op(8, 32'h35, 32'h12, 1'b0, 32'h23, 0, 0, 0, 3);
        run_op(8, 32'h00, 32'h01, 1'b0, 32'hFF, 1, 0, 0, 0);
        run_op(8, 32'h80, 32'h01, 1'b0, 32'h7F, 0, 1, 0, 1);
        run_op(8, 32'h7F, 32'hFF, 1'b0, 32'h80, 1, 1, 0, 0);
        run_op(8, 32'h05, 32'h04, 1'b1, 32'h00, 0, 0, 1, 2);
        run_op(8, 32'h10, 32'h10, 1'b1, 32'hFF, 1, 0, 0, 0);

        // start during RUN is ignored; start with ack in DONE only acks.
        sel = 1'b0;
        launch(32'h35, 32'h12, 1'b0);
        repeat (2) @(negedge clk);
        x = 32'h99; y = 32'h11; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(5);
        check_res(32'h23, 0, 0, 0);
        x = 32'h44; y = 32'h01; start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("sa_ready", rdy, 1);
        chk("sa_valid", vld, 0);
        @(negedge clk);
        chk("sa_nolaunch", rdy, 1);
        chk("sa_retainD", dobs, 32'h23);

        // Asynchronous reset mid-RUN aborts and clears results.
        launch(32'h80, 32'h01, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", vld, 0);
        chk("arst_ready", rdy, 1);
        chk("arst_D", dobs, 0);
        chk("arst_flags", {bo, ov, zr}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8, 32'h80, 32'h01, 1'b0, 32'h7F, 0, 1, 0, 0);

        // Randomized against the reference model.
        for (int k = 0; k < 600; k++) begin
            w   = (k < 300) ? 8 : 16;
            msk = (w == 8) ? 32'hFF : 32'hFFFF;
            ra  = $urandom & msk;
            rb  = $urandom & msk;
            if (k % 17 == 0) rb = ra;
            rbi = 1'($urandom_range(0, 1));
            model(w, ra, rb, rbi, ed, eb, eo, ez);
            run_op(w, ra, rb, rbi, ed, eb, eo, ez, $urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
